// File: rtl/sync3_pkg.sv
// Shared types for the three-lane FIFO drain.
// Lane indices, row layout and lane-counter states.
package sync3_pkg;

  localparam int LANE_COUNT     = 3;
  localparam int DATA_WIDTH_DEF = 64;

  typedef logic [1:0] lane_t;

  typedef logic [LANE_COUNT*DATA_WIDTH_DEF-1:0] row_t;

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2
  } lane_st_e;

endpackage

// File: rtl/sync_3_fifo_drain_row_buffer_2.sv
// Two-entry row store with occupancy and wrapping pointers.
// Lane 0 sits in the low word of each row.
module row_buffer_2
  import sync3_pkg::*;
#(
  parameter int W = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [LANE_COUNT*W-1:0] push_data,
  input  logic                  pop,
  output logic [LANE_COUNT*W-1:0] head_data,
  output logic [1:0]            occ
);

  logic [LANE_COUNT*W-1:0] mem [2];
  logic                    head_ptr;
  logic                    tail_ptr;

  // storage and pointers; reset clears rows so idle payload reads 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= ~tail_ptr;
      end
      if (pop) begin
        head_ptr <= ~head_ptr;
      end
    end
  end

  // occupancy; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[head_ptr];

endmodule

// File: rtl/sync_3_fifo_drain.sv
// Drains the three-lane result FIFO a row at a time
// and serializes each row as three tagged beats.
module sync_3_fifo_drain
  import sync3_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty_in,
  output logic                   fifo_read_en_out,
  input  logic [DATA_WIDTH-1:0]  fifo_data_0_in,
  input  logic [DATA_WIDTH-1:0]  fifo_data_1_in,
  input  logic [DATA_WIDTH-1:0]  fifo_data_2_in,
  output logic                   out_valid_out,
  input  logic                   out_ready_in,
  output logic [DATA_WIDTH-1:0]  out_data_out,
  output logic [1:0]             out_lane_out,
  output logic                   out_last_out,
  output logic [COUNT_WIDTH-1:0] row_count_out,
  output logic                   busy_out
);

  localparam int RW = LANE_COUNT * DATA_WIDTH;

  logic [1:0]    occ;
  logic          inflight;
  logic [RW-1:0] head_row;
  logic          pop_ok;
  logic          fire;
  logic          retire;
  lane_st_e      lane_q;
  lane_st_e      lane_d;

  row_buffer_2 #(
    .W (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data ({fifo_data_2_in,
                 fifo_data_1_in,
                 fifo_data_0_in}),
    .pop       (retire),
    .head_data (head_row),
    .occ       (occ)
  );

  // registered occ only, so ready never reaches read_en
  assign pop_ok = ({1'b0, occ} + {2'b00, inflight}) < 3'd2;

  assign fifo_read_en_out = rst_n & ~fifo_empty_in & pop_ok;

  // a pop's data lands one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fifo_read_en_out;
  end

  assign out_valid_out = (occ != 2'd0);
  assign fire          = out_valid_out & out_ready_in;
  assign retire        = fire & (lane_q == LANE2);

  // lane counter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lane_q <= LANE0;
    else        lane_q <= lane_d;
  end

  // lane counter advances on each accepted beat
  always_comb begin
    lane_d = lane_q;
    if (fire) begin
      unique case (1'b1)
        lane_q == LANE0: lane_d = LANE1;
        lane_q == LANE1: lane_d = LANE2;
        default:         lane_d = LANE0;
      endcase
    end
  end

  // beat payload picks the head row word for the current lane
  always_comb begin
    out_data_out = head_row[DATA_WIDTH-1:0];
    unique case (1'b1)
      lane_q == LANE1:
        out_data_out = head_row[2*DATA_WIDTH-1:DATA_WIDTH];
      lane_q == LANE2:
        out_data_out = head_row[RW-1:2*DATA_WIDTH];
      default:
        out_data_out = head_row[DATA_WIDTH-1:0];
    endcase
  end

  assign out_lane_out = lane_t'(lane_q);
  assign out_last_out = (lane_q == LANE2);

  // completed rows, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      row_count_out <= '0;
    else if (retire) row_count_out <= row_count_out + 1'b1;
  end

  assign busy_out = (occ != 2'd0) | inflight;

endmodule

// File: tb/tb_sync_3_fifo_drain.sv
// Directed bench for sync_3_fifo_drain with a FIFO model
// and a beat monitor; 4-bit counter to exercise wrap.
module tb_sync_3_fifo_drain;

  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] d0 = '0;
  logic [DW-1:0] d1 = '0;
  logic [DW-1:0] d2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    out_lane;
  logic          out_last;
  logic [CW-1:0] row_count;
  logic          busy;

  always #5 clk = ~clk;

  sync_3_fifo_drain #(
    .DATA_WIDTH  (DW),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fifo_empty_in    (fifo_empty),
    .fifo_read_en_out (fifo_rd),
    .fifo_data_0_in   (d0),
    .fifo_data_1_in   (d1),
    .fifo_data_2_in   (d2),
    .out_valid_out    (out_valid),
    .out_ready_in     (out_ready),
    .out_data_out     (out_data),
    .out_lane_out     (out_lane),
    .out_last_out     (out_last),
    .row_count_out    (row_count),
    .busy_out         (busy)
  );

  logic [DW-1:0] m0 [64];
  logic [DW-1:0] m1 [64];
  logic [DW-1:0] m2 [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops   = 0;
  int uflow  = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      if (rd_ptr == wr_ptr) begin
        uflow <= uflow + 1;
      end else begin
        d0     <= m0[rd_ptr];
        d1     <= m1[rd_ptr];
        d2     <= m2[rd_ptr];
        rd_ptr <= rd_ptr + 1;
        pops   <= pops + 1;
      end
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    lane;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t beats [$];
  int    cyc = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n && out_valid && out_ready)
      beats.push_back('{out_data, out_lane, out_last, cyc});
  end

  typedef struct packed {
    logic          rd;
    logic          v;
    logic [1:0]    lane;
    logic          last;
    logic [DW-1:0] data;
    logic          busy;
    logic [CW-1:0] cnt;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int r,
                                         input int l);
    return 64'hC0DE_0000_0000_0000
         | (64'(r) << 8) | 64'(l);
  endfunction

  function automatic vec_t cur();
    vec_t v;
    v.rd   = fifo_rd;
    v.v    = out_valid;
    v.lane = out_lane;
    v.last = out_last;
    v.data = out_data;
    v.busy = busy;
    v.cnt  = row_count;
    return v;
  endfunction

  task automatic push_row(input logic [DW-1:0] a,
                          input logic [DW-1:0] b,
                          input logic [DW-1:0] c);
    m0[wr_ptr] = a;
    m1[wr_ptr] = b;
    m2[wr_ptr] = c;
    wr_ptr++;
  endtask

  task automatic push_n(input int start, input int n);
    for (int i = 0; i < n; i++)
      push_row(word(start + i, 0),
               word(start + i, 1),
               word(start + i, 2));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_beats(input int target,
                            input int budget);
    int k;
    k = 0;
    while (beats.size() < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("beat_budget", 128'(beats.size() >= target), 128'(1));
  endtask

  task automatic check_beats(input int base,
                             input int row0,
                             input int nrows);
    beat_t b;
    int    idx;
    for (int r = 0; r < nrows; r++) begin
      for (int l = 0; l < 3; l++) begin
        idx = base + r * 3 + l;
        if (idx >= beats.size()) begin
          chk("beat_missing", 128'(idx), 128'(beats.size()));
          return;
        end
        b = beats[idx];
        chk("beat", {61'b0, b.lane, b.last, b.data},
            {61'b0, 2'(l), 1'(l == 2), word(row0 + r, l)});
      end
    end
  endtask

  vec_t tv [6];
  vec_t zero_v;
  int   base;
  int   p0;
  int   k;
  int   o;
  int   maxo;
  int   lasts;
  logic [2:0] exp4 [4];

  initial begin
    zero_v = '0;
    tv[0] = '{1'b1, 1'b0, 2'd0, 1'b0, 64'h0,  1'b0, 4'd0};
    tv[1] = '{1'b0, 1'b0, 2'd0, 1'b0, 64'h0,  1'b1, 4'd0};
    tv[2] = '{1'b0, 1'b1, 2'd0, 1'b0, 64'h0A, 1'b1, 4'd0};
    tv[3] = '{1'b0, 1'b1, 2'd1, 1'b0, 64'h0B, 1'b1, 4'd0};
    tv[4] = '{1'b0, 1'b1, 2'd2, 1'b1, 64'h0C, 1'b1, 4'd0};
    tv[5] = '{1'b0, 1'b0, 2'd0, 1'b0, 64'h0,  1'b0, 4'd1};
    exp4[0] = 3'b0_00;
    exp4[1] = 3'b0_01;
    exp4[2] = 3'b0_10;
    exp4[3] = 3'b1_00;

    // single row, cycle by cycle
    do_reset();
    @(negedge clk);
    chk("reset_state", 128'(cur()), 128'(zero_v));
    step();
    out_ready = 1'b1;
    push_row(64'h0A, 64'h0B, 64'h0C);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("single_c%0d", i),
          128'(cur()), 128'(tv[i]));
    end

    // ten rows back to back
    do_reset();
    base = beats.size();
    p0   = pops;
    out_ready = 1'b1;
    push_n(100, 10);
    maxo = 0;
    k    = 0;
    while (beats.size() < base + 30 && k < 300) begin
      @(posedge clk);
      #2;
      lasts = 0;
      for (int i = base; i < beats.size(); i++)
        if (beats[i].last) lasts++;
      o = (pops - p0) - lasts;
      if (o > maxo) maxo = o;
      k++;
    end
    chk("b2b_beats", 128'(beats.size() - base), 128'(30));
    check_beats(base, 100, 10);
    if (beats.size() >= base + 30)
      chk("b2b_no_gap",
          128'(beats[base + 29].cyc - beats[base].cyc),
          128'(29));
    chk("b2b_max_outstanding", 128'(maxo), 128'(2));
    @(negedge clk);
    chk("b2b_count", 128'(row_count), 128'(10));
    chk("b2b_idle", {126'b0, busy, out_valid}, 128'(0));

    // stall mid-row at lane 1
    do_reset();
    base = beats.size();
    p0   = pops;
    out_ready = 1'b1;
    push_n(200, 4);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(out_valid && out_lane == 2'd0) && k < 20);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stall_hold",
          {61'b0, out_valid, out_lane, out_data},
          {61'b0, 1'b1, 2'd1, word(200, 1)});
    end
    chk("stall_pops", 128'(pops - p0), 128'(2));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_beats(base + 12, 100);
    check_beats(base, 200, 4);

    // ready low from the start, five rows queued
    do_reset();
    base = beats.size();
    p0   = pops;
    push_n(300, 5);
    repeat (10) @(negedge clk);
    chk("blocked_pops", 128'(pops - p0), 128'(2));
    chk("blocked_rd", 128'(fifo_rd), 128'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("resume_rd_c%0d", i),
          128'({fifo_rd, out_lane}), 128'(exp4[i]));
    end
    wait_beats(base + 15, 100);
    check_beats(base, 300, 5);
    @(posedge clk);
    @(negedge clk);
    chk("blocked_count", 128'(row_count), 128'(5));

    // counter wrap: 17 rows in a 4-bit counter
    do_reset();
    base = beats.size();
    out_ready = 1'b1;
    push_n(400, 17);
    wait_beats(base + 51, 400);
    check_beats(base, 400, 17);
    @(posedge clk);
    @(negedge clk);
    chk("wrap_count", 128'(row_count), 128'(1));

    // asynchronous reset while lane 1 is presented
    do_reset();
    base = beats.size();
    p0   = pops;
    out_ready = 1'b1;
    push_n(500, 3);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(out_valid && out_lane == 2'd0) && k < 20);
    @(negedge clk);
    chk("pre_rst_lane", 128'({out_valid, out_lane}),
        128'(3'b1_01));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 128'(cur()), 128'(zero_v));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_pop", 128'(fifo_rd), 128'(0));
    end
    chk("rst_pops", 128'(pops - p0), 128'(2));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("release_pop", 128'(fifo_rd), 128'(1));
    wait_beats(base + 5, 100);
    check_beats(base + 2, 502, 1);
    @(posedge clk);
    @(negedge clk);
    chk("rst_count", 128'(row_count), 128'(1));

    chk("no_underflow", 128'(uflow), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_3_fifo_drain.md
# sync_3_fifo_drain

Read-side controller for the three-lane synchronized probe-result FIFO (three 64-bit FIFOs popped in lockstep, one shared read enable, combined empty). It pops one row (lane 0, lane 1, lane 2 words) at a time and accounts for the FIFOs' one-cycle standard-mode read latency. Rows are held in a two-entry row buffer, and each row is serialized onto a single 64-bit valid/ready stream as three beats, with lane tag and last flag. It sits between the probe engine's result FIFOs and the host write-back path.

## Interface
- DATA_WIDTH, 64, width of each lane word and of the output beat
- COUNT_WIDTH, 32, width of the completed-row counter
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fifo_empty_in  in  1  combined empty of the three-lane FIFO (high if any lane empty)
- fifo_read_en_out  out  1  shared pop to all three lanes
- fifo_data_0_in / fifo_data_1_in / fifo_data_2_in  in  DATA_WIDTH each  lane words, valid the cycle after a pop
- out_valid_out  out  1  beat available
- out_ready_in  in  1  downstream accepts beat
- out_data_out  out  DATA_WIDTH  beat payload
- out_lane_out  out  2  lane of current beat (0,1,2)
- out_last_out  out  1  high on lane-2 beat
- row_count_out  out  COUNT_WIDTH  rows fully emitted since reset
- busy_out  out  1  row buffered or pop in flight

## Operation
- Row buffer: 2 entries, each holding 3×DATA_WIDTH. `occ` ∈ {0,1,2}. Head and tail pointers are 1 bit each and wrap.
- `inflight` flag is registered and set on the cycle fifo_read_en_out is high.
- Pop rule (combinational): fifo_read_en_out = !fifo_empty_in && (occ + inflight + 0 < 2), gated low while rst_n is low.
- Capture: in the cycle after a pop, all three lane inputs are written to the tail entry, tail++, occ++, and inflight clears.
- Serializer: a lane counter 0→1→2 selects the head entry word.
  - out_valid_out = (occ != 0).
  - out_lane_out = lane counter; out_last_out = (lane == 2).
- On handshake (valid && ready): lane++. At lane 2 the lane resets to 0, head++, occ--, and row_count_out++ (wraps modulo 2^COUNT_WIDTH).
- Simultaneous capture and row retire: occ is unchanged and both pointers advance.
- A retire in the same cycle frees space for the pop decision only from the next cycle. Pop eligibility uses registered occ, so there is no combinational path from ready to read_en.
- Payload, lane, and last are stable while valid is high and ready is low.
- busy_out = (occ != 0) || inflight.

## Timing
- Reset values: fifo_read_en_out 0, out_valid_out 0, out_lane_out 0, out_last_out 0, out_data_out 0 (buffer cleared), row_count_out 0, busy_out 0. Internal state: occ 0, inflight 0, pointers 0.
- Latency: empty falls in cycle T → pop in T → capture at end of T+1 → out_valid_out high in T+2 with lane 0.
- Sustained throughput: 1 beat/cycle with ready held high, i.e. 1 row per 3 cycles. The output shows no bubbles once the first row has arrived.
- Full: with occ=2, or occ=1 plus inflight, no pop is issued regardless of empty.
- Empty: with fifo_empty_in high, no pop is issued. Rows already buffered still drain.
- Reset mid-operation:
  - In-flight and buffered rows are discarded, and a partially emitted row is dropped without its last beat.
  - The FIFO's own reset must be asserted in the same cycles.

## Structure
- Shared package `sync3_pkg` holds:
  - LANE_COUNT = 3
  - the DATA_WIDTH default
  - the lane index typedef (2-bit)
  - the row typedef (3×DATA_WIDTH)
- Natural sub-module `row_buffer_2`: two-entry row storage with occ and pointers, and push/pop/head-read ports. The top level holds the pop control, inflight flag, lane counter, and counter.

## Test plan
- Single row (lanes 0x0A, 0x0B, 0x0C), ready high: pop in T; beats 0x0A/lane0, 0x0B/lane1, 0x0C/lane2+last in T+2..T+4; row_count 1; busy low at T+5.
- 10 rows back-to-back, ready high: 30 consecutive valid beats with no gaps after the first, row_count 10, never more than 2 rows buffered or in flight.
- Ready low for 8 cycles mid-row (lane 1): data/lane held stable; exactly 2 pops total while stalled; resumes at lane 1.
- Ready low from start with 5 rows queued: only 2 pops issued, and fifo_read_en_out stays low until the first last beat is accepted.
- rst_n asserted while lane 1 is being presented: all outputs return to reset values asynchronously, and no pop occurs until rst_n releases and empty is low.
- Counter wrap with COUNT_WIDTH=4: 17 rows → row_count_out reads 1.
